// File: rtl/gen_reg_file_pkg.sv
// Shared definitions for the general-purpose register file: function encodings
// and the read-select width helper.
package gen_reg_file_pkg;

  typedef enum logic [1:0] {
    FUN_DEC  = 2'd0,
    FUN_INC  = 2'd1,
    FUN_LOAD = 2'd2,
    FUN_CLR  = 2'd3
  } fun_sel_e;

  // Bits needed to index n registers (at least one bit).
  function automatic int unsigned sel_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/gen_reg_file_reg_cell.sv
// One register of the file: decrement / increment / load (full or half) / clear,
// with a combinational flag raised when an inc/dec crosses the value limit.
module reg_cell
  import gen_reg_file_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic [1:0]       fun_sel,
  input  logic             half_en,
  input  logic             half_sel,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             limit_hit_c
);

  localparam int unsigned HALF = WIDTH / 2;

  logic [WIDTH-1:0] d_next;
  logic             at_max;
  logic             at_min;

  assign at_max = (q == {WIDTH{1'b1}});
  assign at_min = (q == '0);

  // Next value for the selected function; saturating mode pins the limits.
  always_comb begin
    d_next = q;
    case (fun_sel)
      FUN_DEC:  d_next = (SATURATE && at_min) ? q : q - WIDTH'(1);
      FUN_INC:  d_next = (SATURATE && at_max) ? q : q + WIDTH'(1);
      FUN_LOAD: begin
        if (!half_en)     d_next = din;
        else if (half_sel) d_next = {din[HALF-1:0], q[HALF-1:0]};
        else              d_next = {q[WIDTH-1:HALF], din[HALF-1:0]};
      end
      FUN_CLR:  d_next = '0;
      default:  d_next = q;
    endcase
  end

  // Limit crossing only matters when this register is actually operated on.
  always_comb begin
    limit_hit_c = 1'b0;
    if (en) begin
      limit_hit_c = ((fun_sel == FUN_INC) && at_max) ||
                    ((fun_sel == FUN_DEC) && at_min);
    end
  end

  // Register state; reset wins over any enabled operation.
  always_ff @(posedge CLK) begin
    if (RST)     q <= '0;
    else if (en) q <= d_next;
  end

endmodule

// File: rtl/gen_reg_file.sv
// Register file of NUM_REGS reg_cell instances sharing one function select,
// with two combinational read ports, zero flags and a registered limit event.
module gen_reg_file
  import gen_reg_file_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned NUM_REGS = 4,
  parameter bit          SATURATE = 1'b0
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [1:0]                       FunSel,
  input  logic [NUM_REGS-1:0]              RegSel,
  input  logic                             HalfEn,
  input  logic                             HalfSel,
  input  logic [WIDTH-1:0]                 I,
  input  logic [sel_width(NUM_REGS)-1:0]   OutASel,
  input  logic [sel_width(NUM_REGS)-1:0]   OutBSel,
  output logic [WIDTH-1:0]                 OutA,
  output logic [WIDTH-1:0]                 OutB,
  output logic [NUM_REGS-1:0]              ZeroFlags,
  output logic                             LimitEv
);

  localparam int unsigned SEL_W = sel_width(NUM_REGS);

  logic [WIDTH-1:0]    regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] hit_c;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_cell
    reg_cell #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
    ) u_cell (
      .CLK         (CLK),
      .RST         (RST),
      .en          (~RegSel[k]),
      .fun_sel     (FunSel),
      .half_en     (HalfEn),
      .half_sel    (HalfSel),
      .din         (I),
      .q           (regs_q[k]),
      .limit_hit_c (hit_c[k])
    );

    assign ZeroFlags[k] = (regs_q[k] == '0);
  end

  // Read muxes; an index with no matching register reads zero.
  always_comb begin
    OutA = '0;
    OutB = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (OutASel == SEL_W'(k)) OutA = regs_q[k];
      if (OutBSel == SEL_W'(k)) OutB = regs_q[k];
    end
  end

  // One-cycle event when any enabled register hit a limit on the last edge.
  always_ff @(posedge CLK) begin
    if (RST) LimitEv <= 1'b0;
    else     LimitEv <= |hit_c;
  end

endmodule

// File: tb/tb_gen_reg_file.sv
// Bench for gen_reg_file: wrapping and saturating 4-register files plus a
// 3-register wrapping file (out-of-range select), all on shared stimulus,
// checked against an arithmetic reference model.
module tb_gen_reg_file;

  localparam int unsigned W    = 8;
  localparam int unsigned N    = 4;
  localparam int unsigned MAXV = 255;
  localparam int unsigned HM   = 16;

  logic         CLK = 1'b0;
  logic         RST;
  logic [1:0]   FunSel;
  logic [N-1:0] RegSel;
  logic         HalfEn;
  logic         HalfSel;
  logic [W-1:0] I;
  logic [1:0]   OutASel;
  logic [1:0]   OutBSel;

  logic [W-1:0] a0, b0, a1, b1, a2, b2;
  logic [N-1:0] z0, z1;
  logic [2:0]   z2;
  logic         l0, l1, l2;

  int unsigned m0 [N];
  int unsigned m1 [N];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 CLK = ~CLK;

  gen_reg_file #(.WIDTH(W), .NUM_REGS(N), .SATURATE(1'b0)) u_wrap (
    .CLK(CLK), .RST(RST), .FunSel(FunSel), .RegSel(RegSel), .HalfEn(HalfEn),
    .HalfSel(HalfSel), .I(I), .OutASel(OutASel), .OutBSel(OutBSel),
    .OutA(a0), .OutB(b0), .ZeroFlags(z0), .LimitEv(l0));

  gen_reg_file #(.WIDTH(W), .NUM_REGS(N), .SATURATE(1'b1)) u_sat (
    .CLK(CLK), .RST(RST), .FunSel(FunSel), .RegSel(RegSel), .HalfEn(HalfEn),
    .HalfSel(HalfSel), .I(I), .OutASel(OutASel), .OutBSel(OutBSel),
    .OutA(a1), .OutB(b1), .ZeroFlags(z1), .LimitEv(l1));

  gen_reg_file #(.WIDTH(W), .NUM_REGS(3), .SATURATE(1'b0)) u_three (
    .CLK(CLK), .RST(RST), .FunSel(FunSel), .RegSel(RegSel[2:0]), .HalfEn(HalfEn),
    .HalfSel(HalfSel), .I(I), .OutASel(OutASel), .OutBSel(OutBSel),
    .OutA(a2), .OutB(b2), .ZeroFlags(z2), .LimitEv(l2));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour of one register for one enabled operation.
  function automatic int unsigned ref_op(input int unsigned v, input int unsigned fs,
                                         input bit he, input bit hs, input int unsigned i,
                                         input bit sat, output bit hit);
    int unsigned r;
    hit = 1'b0;
    r   = v;
    case (fs)
      0: if (v == 0) begin hit = 1'b1; r = sat ? 0 : MAXV; end else r = v - 1;
      1: if (v == MAXV) begin hit = 1'b1; r = sat ? MAXV : 0; end else r = v + 1;
      2: if (!he) r = i;
         else if (hs) r = (i % HM) * HM + (v % HM);
         else r = (v / HM) * HM + (i % HM);
      default: r = 0;
    endcase
    return r;
  endfunction

  function automatic logic [N-1:0] zf_of(input int unsigned m [N]);
    logic [N-1:0] z;
    for (int k = 0; k < N; k++) z[k] = (m[k] == 0);
    return z;
  endfunction

  // Drive one operation, check pre-edge reads, then check the limit event.
  task automatic do_cycle(input bit rst, input int unsigned fs, input logic [N-1:0] rs,
                          input bit he, input bit hs, input int unsigned i,
                          input int unsigned as, input int unsigned bs);
    int unsigned n0 [N];
    int unsigned n1 [N];
    bit h, e0, e1, e2;
    logic [N-1:0] zexp;
    @(negedge CLK);
    RST = rst; FunSel = 2'(fs); RegSel = rs; HalfEn = he; HalfSel = hs;
    I = W'(i); OutASel = 2'(as); OutBSel = 2'(bs);
    #1;
    check_val("wrap_outa", a0, m0[as]);
    check_val("wrap_outb", b0, m0[bs]);
    check_val("wrap_zero", z0, zf_of(m0));
    check_val("sat_outa", a1, m1[as]);
    check_val("sat_outb", b1, m1[bs]);
    check_val("sat_zero", z1, zf_of(m1));
    check_val("three_outa", a2, (as < 3) ? m0[as] : 0);
    check_val("three_outb", b2, (bs < 3) ? m0[bs] : 0);
    zexp = zf_of(m0);
    check_val("three_zero", z2, zexp[2:0]);
    e0 = 1'b0; e1 = 1'b0; e2 = 1'b0;
    for (int k = 0; k < N; k++) begin
      n0[k] = m0[k];
      n1[k] = m1[k];
      if (rst) begin
        n0[k] = 0;
        n1[k] = 0;
      end else if (!rs[k]) begin
        n0[k] = ref_op(m0[k], fs, he, hs, i, 1'b0, h);
        e0 |= h;
        if (k < 3) e2 |= h;
        n1[k] = ref_op(m1[k], fs, he, hs, i, 1'b1, h);
        e1 |= h;
      end
    end
    @(posedge CLK);
    #1;
    for (int k = 0; k < N; k++) begin
      m0[k] = n0[k];
      m1[k] = n1[k];
    end
    check_val("wrap_limit", l0, e0);
    check_val("sat_limit", l1, e1);
    check_val("three_limit", l2, e2);
  endtask

  // Hold all registers and compare against fixed expected values.
  task automatic peek(input string tag, input int unsigned sel,
                      input int unsigned e0, input int unsigned e1,
                      input logic [N-1:0] ez0, input logic [N-1:0] ez1,
                      input bit el0, input bit el1);
    @(negedge CLK);
    RST = 1'b0; RegSel = '1; FunSel = 2'd0; HalfEn = 1'b0;
    OutASel = 2'(sel); OutBSel = 2'(sel);
    #1;
    check_val({tag, "_wrap_a"}, a0, e0);
    check_val({tag, "_wrap_b"}, b0, e0);
    check_val({tag, "_wrap_zf"}, z0, ez0);
    check_val({tag, "_wrap_lim"}, l0, el0);
    check_val({tag, "_sat_a"}, a1, e1);
    check_val({tag, "_sat_b"}, b1, e1);
    check_val({tag, "_sat_zf"}, z1, ez1);
    check_val({tag, "_sat_lim"}, l1, el1);
    check_val({tag, "_three_a"}, a2, (sel < 3) ? e0 : 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned ri;
    RST = 1'b1; FunSel = 2'd0; RegSel = '1; HalfEn = 1'b0; HalfSel = 1'b0;
    I = '0; OutASel = 2'd0; OutBSel = 2'd0;
    for (int k = 0; k < N; k++) begin m0[k] = 0; m1[k] = 0; end
    repeat (2) @(posedge CLK);

    // Reset after arbitrary contents
    do_cycle(1'b0, 2, 4'b0000, 1'b0, 1'b0, 'h5A, 0, 1);
    do_cycle(1'b0, 1, 4'b0101, 1'b0, 1'b0, 0, 2, 3);
    do_cycle(1'b1, 1, 4'b0000, 1'b0, 1'b0, 'hFF, 0, 3);
    peek("reset", 3, 0, 0, 4'b1111, 4'b1111, 1'b0, 1'b0);

    // Full load of register 0
    do_cycle(1'b0, 2, 4'b1110, 1'b0, 1'b0, 'hA5, 0, 0);
    peek("load", 0, 'hA5, 'hA5, 4'b1110, 4'b1110, 1'b0, 1'b0);

    // Half loads on register 1
    do_cycle(1'b0, 2, 4'b1101, 1'b0, 1'b0, 'h34, 1, 1);
    peek("ld34", 1, 'h34, 'h34, 4'b1100, 4'b1100, 1'b0, 1'b0);
    do_cycle(1'b0, 2, 4'b1101, 1'b1, 1'b1, 'h0C, 1, 1);
    peek("half_hi", 1, 'hC4, 'hC4, 4'b1100, 4'b1100, 1'b0, 1'b0);
    do_cycle(1'b0, 2, 4'b1101, 1'b1, 1'b0, 'h09, 1, 1);
    peek("half_lo", 1, 'hC9, 'hC9, 4'b1100, 4'b1100, 1'b0, 1'b0);

    // Increment from all-ones: wrap vs clamp, one-cycle event
    do_cycle(1'b0, 2, 4'b1011, 1'b0, 1'b0, 'hFF, 2, 2);
    do_cycle(1'b0, 1, 4'b1011, 1'b0, 1'b0, 0, 2, 2);
    peek("inc_ff", 2, 'h00, 'hFF, 4'b1100, 4'b1000, 1'b1, 1'b1);
    peek("inc_ff_after", 2, 'h00, 'hFF, 4'b1100, 4'b1000, 1'b0, 1'b0);

    // Decrement of all registers from 1
    do_cycle(1'b0, 2, 4'b0000, 1'b0, 1'b0, 'h01, 0, 3);
    do_cycle(1'b0, 0, 4'b0000, 1'b0, 1'b0, 0, 1, 2);
    peek("dec_all", 0, 0, 0, 4'b1111, 4'b1111, 1'b0, 1'b0);

    // Reset beats an increment on the same edge; read shows the old value
    do_cycle(1'b0, 2, 4'b0111, 1'b0, 1'b0, 'h77, 3, 3);
    do_cycle(1'b1, 1, 4'b0111, 1'b0, 1'b0, 0, 3, 3);
    peek("rst_inc", 3, 0, 0, 4'b1111, 4'b1111, 1'b0, 1'b0);

    // Randomized operations biased toward the limit values
    for (int n = 0; n < 400; n++) begin
      case ($urandom % 5)
        0: ri = 0;
        1: ri = 1;
        2: ri = 'hFE;
        3: ri = 'hFF;
        default: ri = $urandom % 256;
      endcase
      do_cycle(($urandom % 25) == 0, $urandom % 4, 4'($urandom), 1'($urandom),
               1'($urandom), ri, $urandom % 4, $urandom % 4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gen_reg_file.md
GEN_REG_FILE -- requirements
Module: gen_reg_file

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: register width in bits; even, at least 4.
REQ-002 The block SHALL have parameter NUM_REGS, default 4: register count, from 2 to 16.
REQ-003 The block SHALL have parameter SATURATE, default 0: 0 means inc/dec wrap, 1 means inc/dec clamp at the limits.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port FunSel, input, 2 bits: 0 decrement, 1 increment, 2 load, 3 clear.
REQ-007 The block SHALL have port RegSel, input, NUM_REGS bits: per-register enable, active-low.
REQ-008 The block SHALL have port HalfEn, input, 1 bit: 1 makes a load a half-word load.
REQ-009 The block SHALL have port HalfSel, input, 1 bit: 0 selects the low half, 1 selects the high half.
REQ-010 The block SHALL have port I, input, WIDTH bits: load data.
REQ-011 The block SHALL have ports OutASel and OutBSel, input, clog2(NUM_REGS) bits each: read-port register indices.
REQ-012 The block SHALL have ports OutA and OutB, output, WIDTH bits each: read data.
REQ-013 The block SHALL have port ZeroFlags, output, NUM_REGS bits: bit k is 1 when register k equals 0.
REQ-014 The block SHALL have port LimitEv, output, 1 bit: registered pulse reporting an inc/dec wrap or clamp.

Function
REQ-015 Every register k with RegSel[k]=0 SHALL apply FunSel on the rising CLK edge; a register with RegSel[k]=1 SHALL hold its value.
REQ-016 Several simultaneously enabled registers SHALL each apply the same FunSel to their own current value.
REQ-017 A load with HalfEn=0 SHALL write I in full.
REQ-018 A load with HalfEn=1 SHALL write I[WIDTH/2-1:0] into the half chosen by HalfSel and keep the other half.
REQ-019 HalfEn SHALL be ignored for FunSel values 0, 1 and 3.
REQ-020 With SATURATE=0, increment SHALL wrap all-ones to 0 and decrement SHALL wrap 0 to all-ones, modulo 2^WIDTH.
REQ-021 With SATURATE=1, increment of all-ones SHALL hold all-ones and decrement of 0 SHALL hold 0.
REQ-022 LimitEv SHALL be 1 for exactly the cycle after an edge on which any enabled register incremented from all-ones or decremented from 0, in either SATURATE mode, and 0 otherwise.
REQ-023 OutA and OutB SHALL be combinational reads of the registers indexed by OutASel and OutBSel, and SHALL follow both the select and the register contents with zero latency.
REQ-024 A read in the same cycle as a write to that register SHALL return the pre-edge value, with no bypass.
REQ-025 Both read ports SHALL be allowed to select the same register.
REQ-026 A select index of NUM_REGS or more SHALL read 0.
REQ-027 ZeroFlags SHALL be combinational from the register contents.

Reset
REQ-028 When RST=1 at a rising CLK edge, all registers SHALL become 0 and LimitEv SHALL become 0, regardless of RegSel and FunSel.
REQ-029 After reset, OutA=0, OutB=0 and ZeroFlags=all ones SHALL hold.
REQ-030 RST asserted during any operation SHALL take priority, and no partial update SHALL occur.
REQ-031 The first operation after release SHALL be the one presented on the first edge where RST=0.

Structure
REQ-032 A shared package SHALL hold the FunSel encodings (FUN_DEC=0, FUN_INC=1, FUN_LOAD=2, FUN_CLR=3) and a function computing the select width from NUM_REGS.
REQ-033 A single sub-module, reg_cell, SHALL be parametrised by WIDTH and SATURATE and implement one register with enable, FunSel, half-load and a limit-hit output.
REQ-034 gen_reg_file SHALL instantiate NUM_REGS reg_cell instances in a generate loop and OR their limit-hit outputs into the LimitEv flop.

Verification
REQ-035 Reset with RST=1 for one edge after arbitrary contents SHALL give all registers 0, ZeroFlags=4'b1111 and LimitEv=0.
REQ-036 Load I=8'hA5 with RegSel=4'b1110, then OutASel=0 and OutBSel=0, SHALL give OutA=OutB=8'hA5 and ZeroFlags=4'b1110.
REQ-037 Register 1 at 8'h34, then a load with HalfEn=1, HalfSel=1, I=8'h0C, SHALL give 8'hC4; a following load with HalfSel=0, I=8'h09 SHALL give 8'hC9.
REQ-038 With SATURATE=0, register 2 at 8'hFF incremented SHALL become 8'h00, with LimitEv=1 for one cycle; with SATURATE=1 the same stimulus SHALL leave 8'hFF, again with LimitEv=1 for one cycle.
REQ-039 RegSel=4'b0000 with decrement from all registers at 8'h01 SHALL give all registers 8'h00, ZeroFlags=4'b1111 and LimitEv=0.
REQ-040 Increment on register 3 with RST=1 on the same edge SHALL leave register 3 at 0 and LimitEv=0, and the read of register 3 in the write cycle SHALL show the old value.
